// File: rtl/abm_dispatcher_if.sv
// Copy-engine request channel: valid/ready request carrying sequence number and ping-pong buffer index,
// plus the engine's one-cycle completion strobe.
interface abm_dispatcher_if #(
  parameter int SEQ_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [SEQ_WIDTH-1:0] req_seq;
  logic                 req_buf;
  logic                 xfer_done;

  modport master (
    output req_valid,
    output req_seq,
    output req_buf,
    input  req_ready,
    input  xfer_done
  );

  modport slave (
    input  req_valid,
    input  req_seq,
    input  req_buf,
    output req_ready,
    output xfer_done
  );
endinterface

// File: rtl/abm_dispatcher.sv
// abm_dispatcher: queues abm_ready strobes and issues one ping-pong copy request per strobe; 2-cycle strobe-to-request
// latency, request held stable under req_ready backpressure; WAIT watchdog compiled in with ABM_DISPATCH_TIMEOUT_EN.
module abm_dispatcher #(
  parameter int PEND_WIDTH     = 4,
  parameter int SEQ_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  abm_ready,
  input  logic                  enable,
  abm_dispatcher_if.master      cpy,
  output logic                  busy,
  output logic [PEND_WIDTH-1:0] pending,
  output logic [15:0]           overrun_count,
  output logic                  timeout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [SEQ_WIDTH-1:0] seq;
    logic                 buf_sel;
  } hdr_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("abm_dispatcher: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  hdr_t                  hdr_q, hdr_d;
  logic [PEND_WIDTH-1:0] pend_q, pend_d;
  logic [15:0]           ovr_q, ovr_d;
  logic                  start;
  logic                  complete;
  logic                  expire;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      hdr_q   <= '0;
      pend_q  <= '0;
      ovr_q   <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  // enable only gates leaving IDLE; an issued request always runs to completion
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    complete = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && (pend_q != '0)) begin
          state_d = S_REQ;
          start   = 1'b1;
        end
      end
      S_REQ: begin
        if (cpy.req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cpy.xfer_done || expire) begin
          state_d  = S_IDLE;
          complete = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    hdr_d = hdr_q;
    if (complete) begin
      hdr_d.seq     = hdr_q.seq + SEQ_WIDTH'(1);
      hdr_d.buf_sel = ~hdr_q.buf_sel;
    end
  end

  // A strobe landing on the same edge as an issue is absorbed without touching a full counter
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (abm_ready && !start) begin
      if (&pend_q) begin
        if (!(&ovr_q)) begin
          ovr_d = ovr_q + 16'd1;
        end
      end else begin
        pend_d = pend_q + PEND_WIDTH'(1);
      end
    end else if (start && !abm_ready) begin
      pend_d = pend_q - PEND_WIDTH'(1);
    end
  end

`ifdef ABM_DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wd_q;
  logic          tmo_q;

  // Counter idles at zero outside WAIT, so every WAIT entry starts from a clean count
  assign expire = (state_q == S_WAIT) && !cpy.xfer_done && (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wd_q  <= '0;
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= expire;
      if (state_q == S_WAIT) begin
        wd_q <= wd_q + TW'(1);
      end else begin
        wd_q <= '0;
      end
    end
  end

  assign timeout = tmo_q;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign cpy.req_valid = (state_q == S_REQ);
  assign cpy.req_seq   = hdr_q.seq;
  assign cpy.req_buf   = hdr_q.buf_sel;
  assign busy          = (state_q != S_IDLE);
  assign pending       = pend_q;
  assign overrun_count = ovr_q;

  a_req_stable: assert property (@(posedge clk) disable iff (!resetn)
    (cpy.req_valid && !cpy.req_ready) |=> (cpy.req_valid && $stable(cpy.req_seq) && $stable(cpy.req_buf)));

  a_timeout_pulse: assert property (@(posedge clk) disable iff (!resetn)
    timeout |=> !timeout);

endmodule

// File: tb/tb_abm_dispatcher.sv
// Randomized and directed bench for abm_dispatcher against a transfer-level reference model.
module tb_abm_dispatcher;
  localparam int PW   = 4;
  localparam int SW   = 32;
  localparam int TC   = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          abm_ready;
  logic          enable;
  logic          busy;
  logic [PW-1:0] pending;
  logic [15:0]   overrun_count;
  logic          timeout;

  abm_dispatcher_if #(.SEQ_WIDTH(SW)) cpy();

  abm_dispatcher #(
    .PEND_WIDTH(PW),
    .SEQ_WIDTH(SW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .abm_ready(abm_ready),
    .enable(enable),
    .cpy(cpy),
    .busy(busy),
    .pending(pending),
    .overrun_count(overrun_count),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = nothing outstanding, 1 = request offered, 2 = transfer in flight
  int m_phase, m_pend, m_ovr, m_done, m_wait;
  bit m_tmo;

  task automatic model_edge(input bit rn, input bit a, input bit en, input bit rdy, input bit xd);
    bit issue;
    m_tmo = 1'b0;
    if (!rn) begin
      m_phase = 0; m_pend = 0; m_ovr = 0; m_done = 0; m_wait = 0;
      return;
    end
    issue = (m_phase == 0) && en && (m_pend > 0);
    if (a && !issue) begin
      if (m_pend == PMAX) m_ovr = (m_ovr >= 65535) ? 65535 : m_ovr + 1;
      else m_pend = m_pend + 1;
    end else if (issue && !a) begin
      m_pend = m_pend - 1;
    end
    if (m_phase == 0) begin
      if (issue) m_phase = 1;
    end else if (m_phase == 1) begin
      if (rdy) begin m_phase = 2; m_wait = 0; end
    end else begin
      m_wait = m_wait + 1;
      if (xd) begin
        m_phase = 0; m_done = m_done + 1;
      end
`ifdef ABM_DISPATCH_TIMEOUT_EN
      else if (m_wait == TC) begin
        m_phase = 0; m_done = m_done + 1; m_tmo = 1'b1;
      end
`endif
    end
  endtask

  function automatic logic [55:0] exp_vec();
    logic [31:0] s;
    s = 32'(m_done);
    return {(m_phase != 0), (m_phase == 1), s, s[0], 4'(m_pend), 16'(m_ovr), m_tmo};
  endfunction

  function automatic logic [55:0] obs_vec();
    return {busy, cpy.req_valid, cpy.req_seq, cpy.req_buf, pending, overrun_count, timeout};
  endfunction

  task automatic tick(input bit a, input bit en, input bit rdy, input bit xd);
    abm_ready = a; enable = en; cpy.req_ready = rdy; cpy.xfer_done = xd;
    @(posedge clk);
    model_edge(resetn, a, en, rdy, xd);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs_vec() !== 56'd0) begin
        errors++; $display("FAIL reset_hold: got %h want %h", obs_vec(), 56'd0);
      end
    end
    resetn = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 56'd0) begin
      errors++; $display("FAIL reset_release: got %h want %h", obs_vec(), 56'd0);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({cpy.req_valid, pending} !== {1'b0, 4'd1}) begin
      errors++; $display("FAIL single_pend: got %b want %b", {cpy.req_valid, pending}, {1'b0, 4'd1});
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({cpy.req_valid, cpy.req_seq, cpy.req_buf, pending} !== {1'b1, 32'd0, 1'b0, 4'd0}) begin
      errors++; $display("FAIL single_req: got %h want %h",
        {cpy.req_valid, cpy.req_seq, cpy.req_buf, pending}, {1'b1, 32'd0, 1'b0, 4'd0});
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({busy, cpy.req_valid} !== 2'b10) begin
      errors++; $display("FAIL single_wait: got %b want 10", {busy, cpy.req_valid});
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL single_hold cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({busy, cpy.req_seq, cpy.req_buf} !== {1'b0, 32'd1, 1'b1}) begin
      errors++; $display("FAIL single_done: got %h want %h", {busy, cpy.req_seq, cpy.req_buf}, {1'b0, 32'd1, 1'b1});
    end
  endtask

  task automatic test_backpressure();
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if ({cpy.req_valid, cpy.req_seq, cpy.req_buf} !== {1'b1, 32'd1, 1'b1}) begin
        errors++; $display("FAIL bp_stable cyc%0d: got %h want %h", i,
          {cpy.req_valid, cpy.req_seq, cpy.req_buf}, {1'b1, 32'd1, 1'b1});
      end
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({busy, cpy.req_valid} !== 2'b10) begin
      errors++; $display("FAIL bp_accept: got %b want 10", {busy, cpy.req_valid});
    end
  endtask

  task automatic test_queueing();
    int issued = 0;
    int cyc = 0;
    bit rdy, xd;
    for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, pending} !== {1'b1, 4'd3}) begin
      errors++; $display("FAIL queue_fill: got %h want %h", {busy, pending}, {1'b1, 4'd3});
    end
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    while (!(issued == 3 && !busy) && cyc < 100) begin
      rdy = 1'($urandom_range(0, 1));
      xd  = ($urandom_range(0, 3) == 0);
      if (cpy.req_valid && rdy) begin
        checks++;
        if ({cpy.req_seq, cpy.req_buf} !== {32'(2 + issued), 1'((2 + issued) % 2)}) begin
          errors++; $display("FAIL queue_order #%0d: got seq %0d buf %0d want seq %0d buf %0d", issued,
            cpy.req_seq, cpy.req_buf, 2 + issued, (2 + issued) % 2);
        end
        issued++;
      end
      tick(1'b0, 1'b1, rdy, xd);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL queue_cycle %0d: got %h want %h", cyc, obs_vec(), exp_vec());
      end
      cyc++;
    end
    checks++;
    if (issued != 3 || busy !== 1'b0 || pending !== 4'd0) begin
      errors++; $display("FAIL queue_drain: got issued=%0d busy=%b pending=%0d want 3 0 0", issued, busy, pending);
    end
  endtask

  task automatic test_back_to_back();
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if ({busy, cpy.req_valid, pending} !== {2'b00, 4'd1}) begin
      errors++; $display("FAIL b2b_gap: got %h want %h", {busy, cpy.req_valid, pending}, {2'b00, 4'd1});
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({cpy.req_valid, pending} !== {1'b1, 4'd0}) begin
      errors++; $display("FAIL b2b_next: got %h want %h", {cpy.req_valid, pending}, {1'b1, 4'd0});
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL b2b_end: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overrun();
    resetn = 1'b0; tick(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 17; i++) tick(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({pending, overrun_count, busy} !== {4'd15, 16'd2, 1'b0}) begin
      errors++; $display("FAIL overrun_sat: got %h want %h", {pending, overrun_count, busy}, {4'd15, 16'd2, 1'b0});
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({pending, overrun_count, cpy.req_valid} !== {4'd15, 16'd2, 1'b1}) begin
      errors++; $display("FAIL overrun_net0: got %h want %h", {pending, overrun_count, cpy.req_valid}, {4'd15, 16'd2, 1'b1});
    end
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({pending, overrun_count} !== {4'd15, 16'd3}) begin
      errors++; $display("FAIL overrun_wait: got %h want %h", {pending, overrun_count}, {4'd15, 16'd3});
    end
  endtask

  task automatic test_reset_mid();
    resetn = 1'b0; tick(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, pending} !== {1'b1, 4'd4}) begin
      errors++; $display("FAIL midrst_setup: got %h want %h", {busy, pending}, {1'b1, 4'd4});
    end
    resetn = 1'b0; tick(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (obs_vec() !== 56'd0) begin
      errors++; $display("FAIL midrst_clear: got %h want %h", obs_vec(), 56'd0);
    end
    resetn = 1'b1; tick(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (obs_vec() !== 56'd0) begin
      errors++; $display("FAIL midrst_stale_done: got %h want %h", obs_vec(), 56'd0);
    end
  endtask

  task automatic test_timeout();
    logic [2:0] want;
    resetn = 1'b0; tick(1'b0, 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b0, 1'b1, 1'b0, 1'b0);
`ifdef ABM_DISPATCH_TIMEOUT_EN
      want = (k < TC) ? 3'b100 : (k == TC) ? 3'b011 : 3'b001;
`else
      want = 3'b100;
`endif
      checks++;
      if ({busy, timeout, cpy.req_seq[0]} !== want) begin
        errors++; $display("FAIL timeout k=%0d: got %b want %b", k, {busy, timeout, cpy.req_seq[0]}, want);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL timeout_model k=%0d: got %h want %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      resetn = ($urandom_range(0, 199) != 0);
      tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; abm_ready = 1'b0; enable = 1'b0;
    cpy.req_ready = 1'b0; cpy.xfer_done = 1'b0;
    m_phase = 0; m_pend = 0; m_ovr = 0; m_done = 0; m_wait = 0; m_tmo = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_queueing();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
